// File: rtl/i2c_req_arbiter.sv
// Round-robin arbiter sharing one I2C master controller between two requesters.
// Latches the winner's fields, launches the master, and returns data plus a completion pulse.
module i2c_req_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int TO_W           = 11
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        REQ0,
    input  logic        REQ1,
    input  logic [6:0]  ADDR0,
    input  logic [6:0]  ADDR1,
    input  logic        RNW0,
    input  logic        RNW1,
    input  logic [15:0] WDATA0,
    input  logic [15:0] WDATA1,
    output logic        ACK0,
    output logic        ACK1,
    output logic        ERR0,
    output logic        ERR1,
    output logic [15:0] RDATA0,
    output logic [15:0] RDATA1,
    output logic        START_STB,
    output logic        RNW,
    output logic [6:0]  I2C_ADDR,
    output logic [15:0] WR_DATA,
    input  logic [15:0] RD_DATA,
    input  logic        DONE,
    output logic        BUSY,
    output logic        OWNER
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LAUNCH = 2'd1,
        S_WAIT   = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    localparam logic [TO_W-1:0] TIMER_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    state_t         state_q, state_d;
    logic [TO_W-1:0] timer_q, timer_d;
    logic           last_q, last_d;
    logic           errflag_q, errflag_d;
    logic           owner_q, owner_d;
    logic           rnw_q, rnw_d;
    logic [6:0]     addr_q, addr_d;
    logic [15:0]    wdata_q, wdata_d;
    logic [15:0]    rdata0_q, rdata0_d;
    logic [15:0]    rdata1_q, rdata1_d;
    logic           ack0_q, ack0_d, ack1_q, ack1_d;
    logic           err0_q, err0_d, err1_q, err1_d;
    logic           start_q, start_d;
    logic           busy_q, busy_d;
    logic           sel_s;

    // On a tie the requester that was not served last wins.
    assign sel_s = (REQ0 && REQ1) ? ~last_q : REQ1;

    // State and output registers; outputs are computed one cycle ahead from the next state.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q   <= S_IDLE;
            timer_q   <= {TO_W{1'b0}};
            last_q    <= 1'b1;
            errflag_q <= 1'b0;
            owner_q   <= 1'b0;
            rnw_q     <= 1'b0;
            addr_q    <= 7'd0;
            wdata_q   <= 16'd0;
            rdata0_q  <= 16'd0;
            rdata1_q  <= 16'd0;
            ack0_q    <= 1'b0;
            ack1_q    <= 1'b0;
            err0_q    <= 1'b0;
            err1_q    <= 1'b0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            last_q    <= last_d;
            errflag_q <= errflag_d;
            owner_q   <= owner_d;
            rnw_q     <= rnw_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            rdata0_q  <= rdata0_d;
            rdata1_q  <= rdata1_d;
            ack0_q    <= ack0_d;
            ack1_q    <= ack1_d;
            err0_q    <= err0_d;
            err1_q    <= err1_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
        end
    end

    // Next-state and datapath update; DONE takes priority over the watchdog.
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        last_d    = last_q;
        errflag_d = errflag_q;
        owner_d   = owner_q;
        rnw_d     = rnw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        rdata0_d  = rdata0_q;
        rdata1_d  = rdata1_q;
        case (state_q)
            S_IDLE: begin
                if (REQ0 || REQ1) begin
                    state_d = S_LAUNCH;
                    owner_d = sel_s;
                    if (sel_s) begin
                        rnw_d   = RNW1;
                        addr_d  = ADDR1;
                        wdata_d = WDATA1;
                    end else begin
                        rnw_d   = RNW0;
                        addr_d  = ADDR0;
                        wdata_d = WDATA0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_LAUNCH: begin
                timer_d = {TO_W{1'b0}};
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (DONE) begin
                    if (rnw_q && owner_q) begin
                        rdata1_d = RD_DATA;
                    end else if (rnw_q) begin
                        rdata0_d = RD_DATA;
                    end else begin
                        rdata0_d = rdata0_q;
                    end
                    errflag_d = 1'b0;
                    state_d   = S_RESP;
                end else if (timer_q == TIMER_LAST) begin
                    errflag_d = 1'b1;
                    state_d   = S_RESP;
                end else begin
                    timer_d = timer_q + TO_W'(1);
                end
            end
            S_RESP: begin
                last_d  = owner_q;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output decode from the next state so the registered outputs align with the state.
    always_comb begin
        start_d = (state_d == S_LAUNCH);
        busy_d  = (state_d != S_IDLE);
        ack0_d  = (state_d == S_RESP) && !owner_d;
        ack1_d  = (state_d == S_RESP) && owner_d;
        err0_d  = ack0_d && errflag_d;
        err1_d  = ack1_d && errflag_d;
    end

    assign ACK0      = ack0_q;
    assign ACK1      = ack1_q;
    assign ERR0      = err0_q;
    assign ERR1      = err1_q;
    assign RDATA0    = rdata0_q;
    assign RDATA1    = rdata1_q;
    assign START_STB = start_q;
    assign RNW       = rnw_q;
    assign I2C_ADDR  = addr_q;
    assign WR_DATA   = wdata_q;
    assign BUSY      = busy_q;
    assign OWNER     = owner_q;

endmodule

// File: tb/tb_i2c_req_arbiter.sv
// Scoreboard bench for i2c_req_arbiter: a default-timeout instance for the data path
// and an 8-cycle-timeout instance for the watchdog scenarios.
module tb_i2c_req_arbiter;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic        RESET;
    logic        REQ0, REQ1, RNW0, RNW1, DONE;
    logic [6:0]  ADDR0, ADDR1;
    logic [15:0] WDATA0, WDATA1, RD_DATA;
    logic        ACK0, ACK1, ERR0, ERR1, START_STB, RNW, BUSY, OWNER;
    logic [15:0] RDATA0, RDATA1, WR_DATA;
    logic [6:0]  I2C_ADDR;

    logic        t_req0, t_req1, t_done;
    logic [15:0] t_rd;
    logic        t_ack0, t_ack1, t_err0, t_err1, t_start, t_rnw, t_busy, t_owner;
    logic [15:0] t_rdata0, t_rdata1, t_wdata;
    logic [6:0]  t_addr;

    i2c_req_arbiter dut (
        .CLK(CLK), .RESET(RESET), .REQ0(REQ0), .REQ1(REQ1), .ADDR0(ADDR0), .ADDR1(ADDR1),
        .RNW0(RNW0), .RNW1(RNW1), .WDATA0(WDATA0), .WDATA1(WDATA1), .ACK0(ACK0), .ACK1(ACK1),
        .ERR0(ERR0), .ERR1(ERR1), .RDATA0(RDATA0), .RDATA1(RDATA1), .START_STB(START_STB),
        .RNW(RNW), .I2C_ADDR(I2C_ADDR), .WR_DATA(WR_DATA), .RD_DATA(RD_DATA), .DONE(DONE),
        .BUSY(BUSY), .OWNER(OWNER)
    );

    i2c_req_arbiter #(.TIMEOUT_CYCLES(8), .TO_W(4)) dut_to (
        .CLK(CLK), .RESET(RESET), .REQ0(t_req0), .REQ1(t_req1), .ADDR0(ADDR0), .ADDR1(ADDR1),
        .RNW0(RNW0), .RNW1(RNW1), .WDATA0(WDATA0), .WDATA1(WDATA1), .ACK0(t_ack0), .ACK1(t_ack1),
        .ERR0(t_err0), .ERR1(t_err1), .RDATA0(t_rdata0), .RDATA1(t_rdata1), .START_STB(t_start),
        .RNW(t_rnw), .I2C_ADDR(t_addr), .WR_DATA(t_wdata), .RD_DATA(t_rd), .DONE(t_done),
        .BUSY(t_busy), .OWNER(t_owner)
    );

    typedef struct {
        bit          owner;
        bit          err;
        logic [15:0] rdata;
    } exp_t;

    exp_t        sb[$];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          start_cnt = 0;
    int          ack1_cnt  = 0;
    int          any_ack_cnt = 0;
    logic [15:0] m_rd0, m_rd1;

    always @(posedge CLK) begin
        if (START_STB) start_cnt <= start_cnt + 1;
        if (ACK1) ack1_cnt <= ack1_cnt + 1;
        if (ACK0 || ACK1 || ERR0 || ERR1) any_ack_cnt <= any_ack_cnt + 1;
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        REQ0 = 1'b0; REQ1 = 1'b0; DONE = 1'b0; RD_DATA = 16'h0000;
        t_req0 = 1'b0; t_req1 = 1'b0; t_done = 1'b0; t_rd = 16'h0000;
        m_rd0 = 16'h0000; m_rd1 = 16'h0000;
        tick(); tick();
        RESET = 1'b1;
        tick();
    endtask

    // Plays the master on the main instance: waits for launch, replies after dly cycles.
    task automatic serve(input int dly, input logic [15:0] rd, output bit ok,
                         output logic [6:0] a, output logic r, output logic [15:0] w,
                         output logic [1:0] acks, output logic [1:0] errs, output logic own);
        ok = 1'b0; a = 7'd0; r = 1'b0; w = 16'd0; acks = 2'b00; errs = 2'b00; own = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (START_STB) break;
            tick();
        end
        if (START_STB) begin
            ok = 1'b1;
            a = I2C_ADDR; r = RNW; w = WR_DATA;
            repeat (dly) tick();
            DONE = 1'b1; RD_DATA = rd;
            tick();
            DONE = 1'b0; RD_DATA = 16'h0000;
            acks = {ACK1, ACK0}; errs = {ERR1, ERR0}; own = OWNER;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if ({ACK0, ACK1, ERR0, ERR1, START_STB, RNW, BUSY, OWNER, I2C_ADDR, WR_DATA, RDATA0, RDATA1} !== 63'd0) begin
            n_fail++;
            $display("FAIL reset_main: outputs %h, required all zero",
                     {ACK0, ACK1, ERR0, ERR1, START_STB, RNW, BUSY, OWNER, I2C_ADDR, WR_DATA, RDATA0, RDATA1});
        end
        n_checks++;
        if ({t_ack0, t_ack1, t_err0, t_err1, t_start, t_rnw, t_busy, t_owner, t_addr, t_wdata, t_rdata0, t_rdata1} !== 63'd0) begin
            n_fail++;
            $display("FAIL reset_to: outputs nonzero, required all zero");
        end
    endtask

    task automatic test_single_read();
        bit ok; logic [6:0] a; logic r; logic [15:0] w; logic [1:0] acks, errs; logic own;
        int st0, a10;
        exp_t e;
        st0 = start_cnt; a10 = ack1_cnt;
        REQ0 = 1'b1; ADDR0 = 7'h50; RNW0 = 1'b1; WDATA0 = 16'h0000;
        m_rd0 = 16'hBEEF;
        sb.push_back('{owner: 1'b0, err: 1'b0, rdata: m_rd0});
        serve(20, 16'hBEEF, ok, a, r, w, acks, errs, own);
        e = sb.pop_front();
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL read_launch: no START_STB within bound"); end
        n_checks++;
        if (a !== 7'h50) begin n_fail++; $display("FAIL read_addr: got %h required 50", a); end
        n_checks++;
        if (acks !== {e.owner, ~e.owner} || errs !== 2'b00 || own !== e.owner) begin
            n_fail++; $display("FAIL read_ack: acks=%b errs=%b owner=%b required owner %b no err", acks, errs, own, e.owner);
        end
        n_checks++;
        if (RDATA0 !== e.rdata) begin n_fail++; $display("FAIL read_rdata0: got %h required %h", RDATA0, e.rdata); end
        tick();
        REQ0 = 1'b0;
        n_checks++;
        if ({ACK0, BUSY} !== 2'b00) begin n_fail++; $display("FAIL read_after: ack0/busy=%b required 00", {ACK0, BUSY}); end
        n_checks++;
        if (start_cnt - st0 !== 1 || ack1_cnt !== a10) begin
            n_fail++; $display("FAIL read_counts: starts=%0d ack1=%0d required 1 and 0", start_cnt - st0, ack1_cnt - a10);
        end
    endtask

    task automatic test_write();
        bit ok; logic [6:0] a; logic r; logic [15:0] w; logic [1:0] acks, errs; logic own;
        exp_t e;
        REQ1 = 1'b1; ADDR1 = 7'h22; RNW1 = 1'b1; WDATA1 = 16'h0000;
        m_rd1 = 16'h1234;
        sb.push_back('{owner: 1'b1, err: 1'b0, rdata: m_rd1});
        serve(3, 16'h1234, ok, a, r, w, acks, errs, own);
        e = sb.pop_front();
        n_checks++;
        if (!ok || acks !== 2'b10 || own !== e.owner || RDATA1 !== e.rdata) begin
            n_fail++; $display("FAIL prior_read1: ok=%b acks=%b rdata1=%h required 10 %h", ok, acks, RDATA1, e.rdata);
        end
        tick();
        REQ1 = 1'b0;
        tick();
        REQ1 = 1'b1; RNW1 = 1'b0; WDATA1 = 16'hA5A5;
        sb.push_back('{owner: 1'b1, err: 1'b0, rdata: m_rd1});
        serve(5, 16'hFFFF, ok, a, r, w, acks, errs, own);
        e = sb.pop_front();
        n_checks++;
        if (!ok || w !== 16'hA5A5 || r !== 1'b0 || a !== 7'h22) begin
            n_fail++; $display("FAIL write_fields: ok=%b wdata=%h rnw=%b addr=%h required a5a5 0 22", ok, w, r, a);
        end
        n_checks++;
        if (acks !== 2'b10 || errs !== 2'b00) begin n_fail++; $display("FAIL write_ack: acks=%b errs=%b required 10 00", acks, errs); end
        n_checks++;
        if (RDATA1 !== e.rdata) begin n_fail++; $display("FAIL write_rdata1: got %h required %h", RDATA1, e.rdata); end
        tick();
        REQ1 = 1'b0;
    endtask

    task automatic test_round_robin();
        bit ok; logic [6:0] a; logic r; logic [15:0] w; logic [1:0] acks, errs; logic own;
        exp_t e;
        int st0;
        do_reset();
        st0 = start_cnt;
        ADDR0 = 7'h10; ADDR1 = 7'h11; RNW0 = 1'b1; RNW1 = 1'b1;
        REQ0 = 1'b1; REQ1 = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if ((k % 2) == 1) m_rd1 = 16'h1000 + 16'(k); else m_rd0 = 16'h1000 + 16'(k);
            sb.push_back('{owner: bit'(k % 2), err: 1'b0, rdata: ((k % 2) == 1) ? m_rd1 : m_rd0});
            serve(3, 16'h1000 + 16'(k), ok, a, r, w, acks, errs, own);
            e = sb.pop_front();
            n_checks++;
            if (!ok || own !== e.owner || acks !== {e.owner, ~e.owner} || a !== (e.owner ? 7'h11 : 7'h10)) begin
                n_fail++; $display("FAIL rr_grant%0d: owner=%b acks=%b addr=%h required owner %b", k, own, acks, a, e.owner);
            end
            n_checks++;
            if ((e.owner ? RDATA1 : RDATA0) !== e.rdata) begin
                n_fail++; $display("FAIL rr_rdata%0d: got %h required %h", k, e.owner ? RDATA1 : RDATA0, e.rdata);
            end
            tick();
        end
        REQ0 = 1'b0; REQ1 = 1'b0;
        tick();
        n_checks++;
        if (start_cnt - st0 !== 4) begin n_fail++; $display("FAIL rr_starts: got %0d required 4", start_cnt - st0); end
    endtask

    task automatic test_timeout();
        int early;
        ADDR0 = 7'h3C; RNW0 = 1'b1;
        t_req0 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (t_start) break;
            tick();
        end
        tick();
        t_done = 1'b1; t_rd = 16'h7777;
        tick();
        t_done = 1'b0; t_rd = 16'h0000;
        n_checks++;
        if (t_ack0 !== 1'b1 || t_rdata0 !== 16'h7777) begin
            n_fail++; $display("FAIL to_warmup: ack0=%b rdata0=%h required 1 7777", t_ack0, t_rdata0);
        end
        tick();
        early = 0;
        for (int i = 0; i < 20; i++) begin
            if (t_start) break;
            tick();
        end
        tick();
        for (int i = 0; i < 8; i++) begin
            if (t_ack0 || t_err0) early++;
            if (i < 7) tick();
        end
        n_checks++;
        if (early !== 0) begin n_fail++; $display("FAIL to_early: %0d early pulses required 0", early); end
        tick();
        n_checks++;
        if ({t_ack0, t_err0} !== 2'b11 || t_rdata0 !== 16'h7777) begin
            n_fail++; $display("FAIL to_abort: ack/err=%b rdata0=%h required 11 7777", {t_ack0, t_err0}, t_rdata0);
        end
        tick();
        t_req0 = 1'b0;
        n_checks++;
        if ({t_busy, t_ack0, t_err0} !== 3'b000) begin
            n_fail++; $display("FAIL to_idle: busy/ack/err=%b required 000", {t_busy, t_ack0, t_err0});
        end
    endtask

    task automatic test_collision();
        t_req0 = 1'b1;
        for (int i = 0; i < 20; i++) begin
            if (t_start) break;
            tick();
        end
        tick();
        repeat (7) tick();
        t_done = 1'b1; t_rd = 16'hC0DE;
        tick();
        t_done = 1'b0; t_rd = 16'h0000;
        n_checks++;
        if ({t_ack0, t_err0} !== 2'b10 || t_rdata0 !== 16'hC0DE) begin
            n_fail++; $display("FAIL collision: ack/err=%b rdata0=%h required 10 c0de", {t_ack0, t_err0}, t_rdata0);
        end
        tick();
        t_req0 = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_wait();
        bit ok; logic [6:0] a; logic r; logic [15:0] w; logic [1:0] acks, errs; logic own;
        exp_t e;
        int n0;
        REQ0 = 1'b1; RNW0 = 1'b1; ADDR0 = 7'h44;
        for (int i = 0; i < 20; i++) begin
            if (START_STB) break;
            tick();
        end
        tick(); tick();
        n0 = any_ack_cnt;
        RESET = 1'b0; REQ0 = 1'b0;
        m_rd0 = 16'h0000; m_rd1 = 16'h0000;
        tick();
        RESET = 1'b1;
        n_checks++;
        if ({ACK0, ACK1, ERR0, ERR1, START_STB, RNW, BUSY, OWNER, I2C_ADDR, WR_DATA, RDATA0, RDATA1} !== 63'd0) begin
            n_fail++; $display("FAIL midreset_outputs: nonzero after reset, required all zero");
        end
        repeat (4) tick();
        n_checks++;
        if (any_ack_cnt !== n0) begin n_fail++; $display("FAIL midreset_pulse: %0d ack/err pulses required 0", any_ack_cnt - n0); end
        REQ1 = 1'b1; RNW1 = 1'b1; ADDR1 = 7'h66;
        m_rd1 = 16'h6161;
        sb.push_back('{owner: 1'b1, err: 1'b0, rdata: m_rd1});
        serve(2, 16'h6161, ok, a, r, w, acks, errs, own);
        e = sb.pop_front();
        n_checks++;
        if (!ok || own !== e.owner || acks !== 2'b10 || RDATA1 !== e.rdata) begin
            n_fail++; $display("FAIL midreset_req1: owner=%b acks=%b rdata1=%h required 1 10 %h", own, acks, RDATA1, e.rdata);
        end
        tick();
        REQ0 = 1'b1; RNW0 = 1'b1; ADDR0 = 7'h55;
        m_rd0 = 16'h5050;
        sb.push_back('{owner: 1'b0, err: 1'b0, rdata: m_rd0});
        serve(2, 16'h5050, ok, a, r, w, acks, errs, own);
        e = sb.pop_front();
        n_checks++;
        if (!ok || own !== e.owner || acks !== 2'b01 || RDATA0 !== e.rdata || a !== 7'h55) begin
            n_fail++; $display("FAIL midreset_tie: owner=%b acks=%b rdata0=%h required 0 01 %h", own, acks, RDATA0, e.rdata);
        end
        tick();
        REQ0 = 1'b0; REQ1 = 1'b0;
        tick();
    endtask

    initial begin
        ADDR0 = 7'd0; ADDR1 = 7'd0; RNW0 = 1'b0; RNW1 = 1'b0; WDATA0 = 16'd0; WDATA1 = 16'd0;
        test_reset();
        test_single_read();
        test_write();
        test_round_robin();
        test_timeout();
        test_collision();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
